// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus signals between mem_ctrl, its requesters and external memory.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  // byte-wide RAM/IO bus
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  // instruction-fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rdy;
  logic [31:0]           if_data;

  // load/store port
  logic                  ls_req;
  logic                  ls_we;
  logic [1:0]            ls_size;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_rdy;
  logic [31:0]           ls_rdata;

  modport slave (
    input  mem_din, io_buffer_full,
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr,
    output if_rdy, if_data,
    output ls_rdy, ls_rdata
  );

  modport master (
    output mem_din, io_buffer_full,
    output if_req, if_addr,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  if_rdy, if_data,
    input  ls_rdy, ls_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory request responder: serialises fetch and load/store requests onto a byte-wide bus.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IF_BYTES   = 4
) (
  input logic       clk_in,
  input logic       rst_in,
  input logic       rdy_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_n;        // bytes in this request
  logic [2:0]            r_cnt;      // read: bytes issued; write: index of byte on the bus
  logic [31:0]           r_wdata;
  logic                  r_is_ls;
  logic                  r_io;       // store into the UART range, subject to stall
  logic                  r_inflight; // mem_din holds byte r_cnt-1 this cycle
  logic [31:0]           r_data;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_if_rdy;
  logic                  r_ls_rdy;
  logic [31:0]           r_if_data;
  logic [31:0]           r_ls_rdata;

  logic [2:0]            w_size_n;
  logic                  w_acc_stall;
  logic [1:0]            w_cap_idx;
  logic [31:0]           w_data_next;
  logic [2:0]            w_next_cnt;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_wr_stall;
  logic [2:0]            w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [7:0]            w_wr_byte;

  // Decode load/store size into a byte count; size 3 behaves as a word.
  always_comb begin
    w_size_n = 3'd4;
    unique case (bus.ls_size)
      2'd0:    w_size_n = 3'd1;
      2'd1:    w_size_n = 3'd2;
      default: w_size_n = 3'd4;
    endcase
  end

  // Datapath helpers for byte issue, capture and store sequencing.
  always_comb begin
    w_acc_stall = (bus.ls_addr[17:16] == 2'b11) && bus.io_buffer_full;
    w_cap_idx   = 2'(r_cnt - 3'd1);
    w_data_next = r_data;
    w_data_next[8*w_cap_idx +: 8] = bus.mem_din;
    w_next_cnt  = r_cnt + 3'd1;
    w_addr_next = r_addr + ADDR_WIDTH'(w_next_cnt);
    w_wr_stall  = r_io && bus.io_buffer_full;
    w_wr_idx    = r_mem_wr ? w_next_cnt : r_cnt;
    w_wr_addr   = r_addr + ADDR_WIDTH'(w_wr_idx);
    w_wr_byte   = r_wdata[8*w_wr_idx[1:0] +: 8];
  end

  // Drive outputs; a paused cycle never writes.
  always_comb begin
    bus.mem_a    = r_mem_a;
    bus.mem_dout = r_mem_dout;
    bus.mem_wr   = r_mem_wr && rdy_in;
    bus.if_rdy   = r_if_rdy;
    bus.if_data  = r_if_data;
    bus.ls_rdy   = r_ls_rdy;
    bus.ls_rdata = r_ls_rdata;
  end

  // Request FSM with registered bus and response outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_is_ls    <= 1'b0;
      r_io       <= 1'b0;
      r_inflight <= 1'b0;
      r_data     <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_if_rdy   <= 1'b0;
      r_ls_rdy   <= 1'b0;
      r_if_data  <= '0;
      r_ls_rdata <= '0;
    end else if (!rdy_in) begin
      // Paused: a byte read in flight is lost, so point the bus back at it for re-issue.
      if (r_state == StRead && r_inflight) begin
        r_inflight <= 1'b0;
        r_cnt      <= r_cnt - 3'd1;
        r_mem_a    <= r_addr + ADDR_WIDTH'(r_cnt - 3'd1);
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          r_mem_a    <= '0;
          r_mem_dout <= '0;
          r_mem_wr   <= 1'b0;
          if (bus.ls_req || bus.if_req) begin
            r_addr     <= bus.ls_req ? bus.ls_addr : bus.if_addr;
            r_n        <= bus.ls_req ? w_size_n : 3'(IF_BYTES);
            r_is_ls    <= bus.ls_req;
            r_wdata    <= bus.ls_wdata;
            r_io       <= bus.ls_req && bus.ls_we && (bus.ls_addr[17:16] == 2'b11);
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_data     <= '0;
            if (bus.ls_req && bus.ls_we) begin
              r_state    <= StWrite;
              r_mem_wr   <= !w_acc_stall;
              r_mem_a    <= w_acc_stall ? '0 : bus.ls_addr;
              r_mem_dout <= bus.ls_wdata[7:0];
            end else begin
              r_state <= StRead;
              r_mem_a <= bus.ls_req ? bus.ls_addr : bus.if_addr;
            end
          end
        end
        StRead: begin
          if (r_inflight) r_data <= w_data_next;
          if (r_inflight && r_cnt == r_n) begin
            r_state <= StDone;
            r_mem_a <= '0;
            if (r_is_ls) begin
              r_ls_rdy   <= 1'b1;
              r_ls_rdata <= w_data_next;
            end else begin
              r_if_rdy  <= 1'b1;
              r_if_data <= w_data_next;
            end
          end else if (r_cnt < r_n) begin
            r_inflight <= 1'b1;
            r_cnt      <= w_next_cnt;
            r_mem_a    <= (w_next_cnt == r_n) ? '0 : w_addr_next;
          end else begin
            r_inflight <= 1'b0;
          end
        end
        StWrite: begin
          if (r_mem_wr && r_cnt == r_n - 3'd1) begin
            r_state    <= StDone;
            r_mem_wr   <= 1'b0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_ls_rdy   <= 1'b1;
          end else begin
            r_cnt      <= w_wr_idx;
            r_mem_wr   <= !w_wr_stall;
            r_mem_a    <= w_wr_stall ? '0 : w_wr_addr;
            r_mem_dout <= w_wr_byte;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_if_rdy <= 1'b0;
          r_ls_rdy <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table plus hand-written reset, arbitration, IO-stall and pause cases.
module tb_mem_ctrl;

  localparam int unsigned AW = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  mem_ctrl #(.ADDR_WIDTH(AW), .IF_BYTES(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM (low 16 address bits) and UART sink at addr[17:16]==3.
  logic [7:0]  ram [0:65535];
  int          io_wr_cnt = 0;
  logic [31:0] io_last_a = '0;
  logic [7:0]  io_last_d = '0;
  int          cyc = 0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) begin
      if (bus.mem_a[17:16] == 2'b11) begin
        io_wr_cnt <= io_wr_cnt + 1;
        io_last_a <= bus.mem_a;
        io_last_d <= bus.mem_dout;
      end else begin
        ram[bus.mem_a[15:0]] <= bus.mem_dout;
      end
    end
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected responses, in request-service order.
  typedef struct {
    logic        is_ls;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int done_cnt  = 0;
  int done_cyc  = 0;
  int if_pulses = 0;
  int ls_pulses = 0;

  always @(negedge clk_in) begin
    if (rst_in && (bus.if_rdy || bus.ls_rdy)) begin
      exp_t e;
      done_cnt++;
      done_cyc = cyc;
      if (bus.if_rdy) if_pulses++;
      if (bus.ls_rdy) ls_pulses++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rdy", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("rdy_src", {31'b0, bus.ls_rdy}, {31'b0, e.is_ls});
        chk("rdy_both", {31'b0, bus.ls_rdy & bus.if_rdy}, 32'd0);
        if (e.chk_data) chk("rdata", e.is_ls ? bus.ls_rdata : bus.if_data, e.data);
      end
    end
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  task automatic drop_req();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
  endtask

  task automatic wait_done(input int start, input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(posedge clk_in); #1;
      if (done_cnt != start) seen = 1'b1;
    end
  endtask

  // Issue one request, check the bus sequence, then check completion count and latency.
  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    int   t0;
    int   start;
    bit   seen;
    exp_t e;
    n = !v.is_ls ? 4 : (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    e.is_ls    = v.is_ls;
    e.chk_data = !v.we;
    e.data     = v.exp_data;
    sb_q.push_back(e);
    start = done_cnt;
    t0    = cyc;
    if (v.is_ls) begin
      bus.ls_req   = 1'b1;
      bus.ls_we    = v.we;
      bus.ls_size  = v.size;
      bus.ls_addr  = v.addr;
      bus.ls_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk_in); #1;
      if (done_cnt != start) begin
        seen = 1'b1;
      end else if (c <= n) begin
        chk({tag, "_a"}, bus.mem_a, v.addr + 32'(c - 1));
        chk({tag, "_wr"}, {31'b0, bus.mem_wr}, {31'b0, v.we});
        if (v.we) chk({tag, "_dout"}, {24'b0, bus.mem_dout}, {24'b0, v.wdata[8*(c-1) +: 8]});
      end
    end
    drop_req();
    chk({tag, "_done"}, 32'(done_cnt - start), 32'd1);
    if (seen) chk({tag, "_lat"}, 32'(done_cyc - t0), 32'(v.exp_lat));
    else if (sb_q.size() != 0) void'(sb_q.pop_back());
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   start;
    int   io0;
    int   p0;
    int   lat;
    bit   seen;
    exp_t e;

    rst_in             = 1'b0;
    rdy_in             = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.if_req         = 1'b0;
    bus.if_addr        = '0;
    bus.ls_req         = 1'b0;
    bus.ls_we          = 1'b0;
    bus.ls_size        = '0;
    bus.ls_addr        = '0;
    bus.ls_wdata       = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13;
    ram[16'h1001] = 8'h05;
    ram[16'h0040] = 8'h8F;
    ram[16'hFFFF] = 8'hA5;
    ram[16'h0000] = 8'h3C;

    //             is_ls we    size  addr           wdata          exp_data       lat
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1000, 32'h0,         32'h0000_0513, 6};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         5};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0021, 32'h0,         32'h0000_ADBE, 4};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0023, 32'h0,         32'h0000_00DE, 3};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0050, 32'h1234_5677, 32'h0,         2};
    vecs[6]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0052, 32'hAABB_CCDD, 32'h0,         3};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0050, 32'h0,         32'hCCDD_0077, 6};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_3CA5, 4};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,         32'h003C_A500, 6};

    // Reset state.
    #12;
    chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_if_rdy", {31'b0, bus.if_rdy}, 32'd0);
    chk("rst_ls_rdy", {31'b0, bus.ls_rdy}, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a word store: only the first two bytes land.
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd2;
    bus.ls_addr  = 32'h80;
    bus.ls_wdata = 32'h1122_3344;
    repeat (3) begin
      @(posedge clk_in); #1;
    end
    chk("abort_wr_before", {31'b0, bus.mem_wr}, 32'd1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("abort_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("abort_mem_a", bus.mem_a, 32'd0);
    chk("abort_ls_rdy", {31'b0, bus.ls_rdy}, 32'd0);
    chk("abort_if_rdy", {31'b0, bus.if_rdy}, 32'd0);
    drop_req();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("abort_b0", {24'b0, ram[16'h80]}, 32'h44);
    chk("abort_b1", {24'b0, ram[16'h81]}, 32'h33);
    chk("abort_b2", {24'b0, ram[16'h82]}, 32'h00);
    chk("abort_b3", {24'b0, ram[16'h83]}, 32'h00);

    // Simultaneous requests: the load wins, the fetch follows after IDLE.
    e = '{1'b1, 1'b1, 32'h0000_008F};
    sb_q.push_back(e);
    e = '{1'b0, 1'b1, 32'h0000_003C};
    sb_q.push_back(e);
    start = done_cnt;
    t0    = cyc;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_size  = 2'd0;
    bus.ls_addr  = 32'h40;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    wait_done(start, 20, seen);
    bus.ls_req = 1'b0;
    chk("arb_ls_lat", 32'(done_cyc - t0), 32'd3);
    start = done_cnt;
    wait_done(start, 20, seen);
    bus.if_req = 1'b0;
    chk("arb_if_lat", 32'(done_cyc - t0), 32'd10);
    @(posedge clk_in); #1;

    // UART store held off by a full buffer, then a single write.
    bus.io_buffer_full = 1'b1;
    e = '{1'b1, 1'b0, 32'h0};
    sb_q.push_back(e);
    start = done_cnt;
    t0    = cyc;
    io0   = io_wr_cnt;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd0;
    bus.ls_addr  = 32'h0003_0000;
    bus.ls_wdata = 32'h0000_0041;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk_in); #1;
      chk($sformatf("io_stall_wr%0d", c), {31'b0, bus.mem_wr}, 32'd0);
      chk($sformatf("io_stall_a%0d", c), bus.mem_a, 32'd0);
    end
    bus.io_buffer_full = 1'b0;
    @(posedge clk_in); #1;
    chk("io_wr", {31'b0, bus.mem_wr}, 32'd1);
    chk("io_a", bus.mem_a, 32'h0003_0000);
    chk("io_dout", {24'b0, bus.mem_dout}, 32'h41);
    @(posedge clk_in); #1;
    chk("io_rdy_next", {31'b0, bus.ls_rdy}, 32'd1);
    chk("io_wr_after", {31'b0, bus.mem_wr}, 32'd0);
    wait_done(start, 5, seen);
    drop_req();
    chk("io_lat", 32'(done_cyc - t0), 32'd5);
    chk("io_wr_cnt", 32'(io_wr_cnt - io0), 32'd1);
    chk("io_last_a", io_last_a, 32'h0003_0000);
    chk("io_last_d", {24'b0, io_last_d}, 32'h41);
    @(posedge clk_in); #1;

    // Global pause while byte 1 of a fetch is in flight.
    e = '{1'b0, 1'b1, 32'h0000_0513};
    sb_q.push_back(e);
    start = done_cnt;
    t0    = cyc;
    p0    = if_pulses;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1000;
    @(posedge clk_in); #1;
    chk("pause_a1", bus.mem_a, 32'h1000);
    @(posedge clk_in); #1;
    chk("pause_a2", bus.mem_a, 32'h1001);
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    chk("pause_wr3", {31'b0, bus.mem_wr}, 32'd0);
    @(posedge clk_in); #1;
    chk("pause_wr4", {31'b0, bus.mem_wr}, 32'd0);
    @(posedge clk_in); #1;
    rdy_in = 1'b1;
    chk("pause_reissue_a", bus.mem_a, 32'h1001);
    wait_done(start, 20, seen);
    bus.if_req = 1'b0;
    lat = done_cyc - t0;
    chk("pause_lat_in_window", {31'b0, (lat == 8 || lat == 9)}, 32'd1);
    repeat (4) @(posedge clk_in);
    #1;
    chk("pause_pulses", 32'(if_pulses - p0), 32'd1);

    chk("sb_left", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
